// File: rtl/axil_fifo_slave_if.sv
// AXI4-Lite bus bundle for the FIFO mailbox slave.
// The slave modport is the peripheral side; the master modport is the CPU/bench side.
interface axil_fifo_slave_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [2:0]            AWPROT;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic [2:0]            ARPROT;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        input  ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
        output ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axil_fifo_slave.sv
// AXI4-Lite slave exposing a synchronous FIFO through DATA/STATUS/CTRL registers.
// DATA write pushes, DATA read pops; status flags are also exported as wires.
module axil_fifo_slave #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6
) (
    input  logic               ACLK,
    input  logic               ARESET_N,
    axil_fifo_slave_if.slave   bus,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic               almost_full
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W  = CNT_W - 1;

    localparam logic [ADDR_W-1:0] AddrData   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] AddrMask   = ~ADDR_W'(STRB_W - 1);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    logic                ready_en_q;
    logic                aw_held_q, aw_held_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic                w_held_q, w_held_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic                aw_hs, w_hs, ar_hs, commit;
    logic                is_empty, is_full;
    logic [ADDR_W-1:0]   waddr, raddr;
    logic                push, pop, flush, clr_sticky, ctrl_wr;
    logic [DATA_W-1:0]   wdata_masked, status_word;
    logic                unused_prot;

    assign unused_prot = ^{bus.AWPROT, bus.ARPROT};

    // READY stays low during reset and rises on the first clock after release.
    assign bus.AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign bus.WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
    assign bus.ARREADY = ready_en_q & ~rvalid_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;

    assign is_empty    = (count_q == '0);
    assign is_full     = (count_q == CNT_W'(DEPTH));
    assign fifo_empty  = is_empty;
    assign fifo_full   = is_full;
    assign almost_full = (count_q >= CNT_W'(AF_THRESH));

    assign aw_hs  = bus.AWVALID & bus.AWREADY;
    assign w_hs   = bus.WVALID & bus.WREADY;
    assign ar_hs  = bus.ARVALID & bus.ARREADY;
    assign commit = aw_held_q & w_held_q;
    assign waddr  = awaddr_q & AddrMask;
    assign raddr  = bus.ARADDR & AddrMask;

    assign push       = commit & (waddr == AddrData) & ~is_full;
    assign pop        = ar_hs & (raddr == AddrData) & ~is_empty;
    assign ctrl_wr    = commit & (waddr == AddrCtrl) & wstrb_q[0];
    assign flush      = ctrl_wr & wdata_q[0];
    assign clr_sticky = ctrl_wr & wdata_q[1];

    always_comb begin
        wdata_masked = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            wdata_masked[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : 8'h00;
        end
        status_word = '0;
        status_word[CNT_W-1:0] = count_q;
        status_word[16] = is_empty;
        status_word[17] = is_full;
        status_word[18] = ovf_q;
        status_word[19] = udf_q;
    end

    // Write channel: latch AW and W independently, commit once both are held.
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = bus.AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = bus.WDATA;
            wstrb_d  = bus.WSTRB;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (waddr == AddrData) begin
                bresp_d = is_full ? RespSlvErr : RespOkay;
            end else if (waddr == AddrStatus) begin
                bresp_d = RespSlvErr;
            end else if (waddr == AddrCtrl) begin
                bresp_d = RespOkay;
            end else begin
                bresp_d = RespDecErr;
            end
        end else if (bvalid_q && bus.BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RespOkay;
            if (raddr == AddrData) begin
                if (is_empty) begin
                    rresp_d = RespSlvErr;
                end else begin
                    rdata_d = mem_q[rd_ptr_q];
                end
            end else if (raddr == AddrStatus) begin
                rdata_d = status_word;
            end else if (raddr != AddrCtrl) begin
                rresp_d = RespDecErr;
            end
        end else if (rvalid_q && bus.RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // Pop uses the pre-push count; a flush overrides any same-cycle pointer motion.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata_masked;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        if (clr_sticky) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (commit && (waddr == AddrData) && is_full) begin
            ovf_d = 1'b1;
        end
        if (ar_hs && (raddr == AddrData) && is_empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage is not reset; only pointers and count define its contents.
    always_ff @(posedge ACLK) begin
        mem_q <= mem_d;
    end
endmodule
